spike_detector: RTL and testbench

- Consumes the 32-bit signed output of fir_filter, one sample per clock, and flags neural spikes.
- Rectifies each sample and detects threshold crossings that persist for at least MIN_ABOVE samples.
- For each detected spike, reports the peak magnitude, increments a saturating event counter, then blanks detection for a refractory window.
- Sits directly downstream of the FIR in the neural-signal path; its outputs feed logging and readout.

---
 rtl/spike_detector.sv | 147 ++++++++++++++
 tb/tb_spike_detector.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/spike_detector.sv
// Spike detector: rectifies filtered samples, qualifies threshold crossings,
// reports peak magnitude and a saturating event count, then blanks for a refractory window.
module spike_detector #(
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16,
  parameter int MIN_ABOVE = 2,
  parameter int MAX_WIDTH = 64,
  parameter int REFRACT   = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic        [DATA_W-1:0] thresh,
  input  logic                     clear_cnt,
  output logic                     spike,
  output logic        [DATA_W-1:0] spike_peak,
  output logic        [CNT_W-1:0]  spike_cnt,
  output logic                     busy
);

  localparam int RUN_W = 4;
  localparam int WID_W = $clog2(MAX_WIDTH + 1);
  localparam int REF_W = $clog2(REFRACT + 1);
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, ARMED, PEAK, REFR} state_t;

  state_t             state, state_n;
  logic [DATA_W-1:0]  abs_c, abs_r, peak_r, peak_n;
  logic               v_r, above, end_spike;
  logic [RUN_W-1:0]   run, run_n;
  logic [WID_W-1:0]   width, width_n;
  logic [REF_W-1:0]   refr, refr_n;
  logic [CNT_W-1:0]   cnt_base, cnt_n;

  // Most-negative input has no positive twin, so clamp it.
  always_comb begin
    abs_c = x_in;
    if (x_in[DATA_W-1])
      abs_c = (x_in == MOST_NEG) ? MOST_POS : (~x_in + 1'b1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      abs_r <= '0;
      v_r   <= 1'b0;
    end else begin
      v_r <= en;
      if (en) abs_r <= abs_c;
    end
  end

  assign above = (abs_r > thresh);

  always_comb begin
    state_n   = state;
    run_n     = run;
    width_n   = width;
    peak_n    = peak_r;
    refr_n    = refr;
    end_spike = 1'b0;
    if (v_r) begin
      case (state)
        IDLE: begin
          if (above) begin
            run_n  = RUN_W'(1);
            peak_n = abs_r;
            if (MIN_ABOVE == 1) begin
              state_n = PEAK;
              width_n = WID_W'(1);
            end else begin
              state_n = ARMED;
            end
          end
        end
        ARMED: begin
          if (above) begin
            run_n  = run + 1'b1;
            peak_n = (abs_r > peak_r) ? abs_r : peak_r;
            if (run_n == RUN_W'(MIN_ABOVE)) begin
              state_n = PEAK;
              width_n = WID_W'(run_n);
            end
          end else begin
            state_n = IDLE;
            run_n   = '0;
            peak_n  = '0;
          end
        end
        PEAK: begin
          if (above) begin
            peak_n  = (abs_r > peak_r) ? abs_r : peak_r;
            width_n = width + 1'b1;
            if (width_n == WID_W'(MAX_WIDTH)) end_spike = 1'b1;
          end else begin
            end_spike = 1'b1;
          end
          if (end_spike) begin
            state_n = REFR;
            refr_n  = REF_W'(REFRACT);
            run_n   = '0;
          end
        end
        REFR: begin
          refr_n = refr - 1'b1;
          if (refr == REF_W'(1)) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Clear is applied before the increment so a coincident event counts as one.
  always_comb begin
    cnt_base = clear_cnt ? '0 : spike_cnt;
    cnt_n    = cnt_base;
    if (end_spike && cnt_base != CNT_MAX) cnt_n = cnt_base + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      run        <= '0;
      width      <= '0;
      peak_r     <= '0;
      refr       <= '0;
      spike      <= 1'b0;
      spike_peak <= '0;
      spike_cnt  <= '0;
      busy       <= 1'b0;
    end else begin
      state     <= state_n;
      run       <= run_n;
      width     <= width_n;
      peak_r    <= peak_n;
      refr      <= refr_n;
      spike     <= end_spike;
      spike_cnt <= cnt_n;
      busy      <= (state_n == PEAK) || (state_n == REFR);
      if (end_spike) spike_peak <= peak_n;
    end
  end

endmodule

// File: tb/tb_spike_detector.sv
// Scoreboard bench for spike_detector: stimulus queues expected spikes, a monitor checks them.
module tb_spike_detector;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               en = 1'b1;
  logic signed [31:0] x_in = '0;
  logic        [31:0] thresh = 32'd1000;
  logic               clear_cnt = 1'b0;
  logic               spike;
  logic        [31:0] spike_peak;
  logic        [3:0]  spike_cnt;
  logic               busy;

  spike_detector #(.DATA_W(32), .CNT_W(4), .MIN_ABOVE(2), .MAX_WIDTH(64), .REFRACT(4)) dut (
    .clk(clk), .rst(rst), .en(en), .x_in(x_in), .thresh(thresh), .clear_cnt(clear_cnt),
    .spike(spike), .spike_peak(spike_peak), .spike_cnt(spike_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] peak;
    int          cnt;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  int   mcnt = 0;
  int   busy_cycles = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input logic signed [31:0] v, input logic clr = 1'b0);
    x_in      = v;
    clear_cnt = clr;
    last_cyc  = cyc;
    @(negedge clk);
    clear_cnt = 1'b0;
    if (busy) busy_cycles++;
  endtask

  task automatic expect_spike(input logic [31:0] peak);
    mcnt = (mcnt == 15) ? 15 : mcnt + 1;
    q.push_back('{last_cyc + 2, peak, mcnt});
  endtask

  task automatic zeros(input int n);
    for (int i = 0; i < n; i++) step(0);
  endtask

  always @(negedge clk) begin
    if (spike) begin
      if (q.size() == 0) begin
        chk("unexpected_spike", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("spike_cycle", cyc, e.cyc);
        chk("spike_peak", spike_peak, e.peak);
        chk("spike_cnt_at_spike", spike_cnt, e.cnt);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_spike", spike, 0);
    chk("reset_peak", spike_peak, 0);
    chk("reset_cnt", spike_cnt, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;
    zeros(2);

    // Blip rejection
    busy_cycles = 0;
    step(0); step(5000); step(0); step(0); zeros(4);
    chk("blip_cnt", spike_cnt, 0);
    chk("blip_busy", busy_cycles, 0);

    // Nominal spike, then refractory blanking of an immediate pair
    busy_cycles = 0;
    step(0); step(1200); step(-3000); step(2500); step(100);
    expect_spike(3000);
    step(1200); step(1500); zeros(6);
    chk("nominal_busy_cycles", busy_cycles, 6);
    chk("refract_cnt", spike_cnt, 1);
    step(1200); step(1500); step(0);
    expect_spike(1500);
    zeros(6);
    chk("after_refract_cnt", spike_cnt, 2);

    // Strict compare at threshold
    step(1000); step(1000); step(0); zeros(4);
    chk("strict_cnt", spike_cnt, 2);

    // Most-negative input saturates
    step(32'sh8000_0000); step(32'sh8000_0000); step(0);
    expect_spike(32'h7FFF_FFFF);
    zeros(6);

    // Long run forced to end at width 64; the tail re-qualifies after refractory
    for (int i = 1; i <= 70; i++) begin
      step(2000);
      if (i == 64) expect_spike(2000);
    end
    step(0);
    expect_spike(2000);
    zeros(6);
    chk("width_cnt", spike_cnt, 5);

    // Plain clear, then saturation at 15
    step(0, 1'b1);
    mcnt = 0;
    chk("clear_cnt", spike_cnt, 0);
    for (int s = 0; s < 16; s++) begin
      step(2000); step(2000); step(0);
      expect_spike(2000);
      zeros(4);
    end
    zeros(2);
    chk("sat_cnt", spike_cnt, 15);

    // Clear coinciding with spike event
    step(2000); step(2500); step(0);
    mcnt = 0;
    expect_spike(2500);
    step(0, 1'b1);
    zeros(6);
    chk("clear_coincident_cnt", spike_cnt, 1);

    // Asynchronous reset while in PEAK with peak 3000
    step(1200); step(3000); step(3000);
    chk("pre_reset_busy", busy, 1);
    x_in = 0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_peak", spike_peak, 0);
    chk("async_rst_cnt", spike_cnt, 0);
    chk("async_rst_spike", spike, 0);
    @(negedge clk);
    rst = 1'b0;
    mcnt = 0;
    zeros(8);
    chk("post_reset_cnt", spike_cnt, 0);
    step(1200); step(1500); step(0);
    expect_spike(1500);
    zeros(6);

    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
